// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_wb_arbiter                                           |
// | Description : Round-robin ALU/load write-back arbiter with a registered    |
// |               register-file write port and a destination scoreboard.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module regfile_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            stall,
    output logic            wen,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] write_data
);
    localparam int c_AW = 5;

    logic            r_ptr;
    logic [NREG-1:0] r_busy;
    logic            r_wen;
    logic [c_AW-1:0] r_rd_addr;
    logic [XLEN-1:0] r_write_data;

    logic            w_alu_ready;
    logic            w_mem_ready;
    logic            w_alu_fire;
    logic            w_mem_fire;
    logic            w_fire;
    logic            w_write;
    logic [c_AW-1:0] w_fire_rd;
    logic [XLEN-1:0] w_fire_data;
    logic [NREG-1:0] w_busy_next;

    // Under contention only the side favoured by r_ptr is granted.
    assign w_alu_ready = ~rst & alu_valid & (~mem_valid | ~r_ptr);
    assign w_mem_ready = ~rst & mem_valid & (~alu_valid |  r_ptr);
    assign w_alu_fire  = alu_valid & w_alu_ready;
    assign w_mem_fire  = mem_valid & w_mem_ready;
    assign w_fire      = w_alu_fire | w_mem_fire;
    assign w_fire_rd   = w_alu_fire ? alu_rd   : mem_rd;
    assign w_fire_data = w_alu_fire ? alu_data : mem_data;
    assign w_write     = w_fire & (w_fire_rd != '0);

    // Issue is applied after the clear so a newer producer stays outstanding.
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 1; i < NREG; i++) begin
            if (w_write && (w_fire_rd == c_AW'(i))) begin
                w_busy_next[i] = 1'b0;
            end
            if (issue_valid && (issue_rd == c_AW'(i))) begin
                w_busy_next[i] = 1'b1;
            end
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= 1'b0;
            r_busy       <= '0;
            r_wen        <= 1'b0;
            r_rd_addr    <= '0;
            r_write_data <= '0;
        end else begin
            r_busy <= w_busy_next;
            r_wen  <= w_write;
            if (w_alu_fire) begin
                r_ptr <= 1'b1;
            end else if (w_mem_fire) begin
                r_ptr <= 1'b0;
            end
            if (w_write) begin
                r_rd_addr    <= w_fire_rd;
                r_write_data <= w_fire_data;
            end
        end
    end

    assign alu_ready  = w_alu_ready;
    assign mem_ready  = w_mem_ready;
    assign rs1_busy   = ~rst & r_busy[rs1_addr];
    assign rs2_busy   = ~rst & r_busy[rs2_addr];
    assign stall      = rs1_busy | rs2_busy;
    assign wen        = r_wen;
    assign rd_addr    = r_rd_addr;
    assign write_data = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_wb_arbiter                                        |
// | Description : Randomised self-checking bench with a queue-based reference. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;
    localparam int XLEN = 64;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } req_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            alu_valid, mem_valid;
    logic            alu_ready, mem_ready;
    logic [4:0]      alu_rd, mem_rd;
    logic [XLEN-1:0] alu_data, mem_data;
    logic            issue_valid;
    logic [4:0]      issue_rd, rs1_addr, rs2_addr;
    logic            rs1_busy, rs2_busy, stall;
    logic            wen;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] write_data;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall),
        .wen(wen), .rd_addr(rd_addr), .write_data(write_data)
    );

    always #5 clk = ~clk;

    // Reference state: pending requests per producer plus architectural view.
    req_t            aq[$];
    req_t            mq[$];
    bit              m_ptr;
    bit [31:0]       m_busy;
    bit              m_wen;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        aq.delete();
        mq.delete();
        m_ptr  = 0;
        m_busy = '0;
        m_wen  = 0;
        m_rd   = '0;
        m_data = '0;
    endtask

    task automatic drive();
        alu_valid = (aq.size() != 0);
        alu_rd    = alu_valid ? aq[0].rd   : 5'd0;
        alu_data  = alu_valid ? aq[0].data : '0;
        mem_valid = (mq.size() != 0);
        mem_rd    = mem_valid ? mq[0].rd   : 5'd0;
        mem_data  = mem_valid ? mq[0].data : '0;
    endtask

    // Checks every output against the reference, then advances the reference.
    task automatic check_and_step();
        bit   a_v, m_v, g_alu, g_mem;
        req_t r;
        a_v   = (aq.size() != 0);
        m_v   = (mq.size() != 0);
        g_alu = !rst && a_v && !(m_v && m_ptr);
        g_mem = !rst && m_v && !g_alu;
        check("alu_ready",  alu_ready,  g_alu);
        check("mem_ready",  mem_ready,  g_mem);
        check("wen",        wen,        m_wen);
        check("rd_addr",    rd_addr,    m_rd);
        check("write_data", write_data, m_data);
        check("rs1_busy",   rs1_busy,   !rst && m_busy[rs1_addr]);
        check("rs2_busy",   rs2_busy,   !rst && m_busy[rs2_addr]);
        check("stall",      stall,      !rst && (m_busy[rs1_addr] || m_busy[rs2_addr]));
        if (rst) return;
        m_wen = 0;
        if (g_alu || g_mem) begin
            r     = g_alu ? aq.pop_front() : mq.pop_front();
            m_ptr = g_alu;
            if (r.rd != 0) begin
                m_wen         = 1;
                m_rd          = r.rd;
                m_data        = r.data;
                m_busy[r.rd]  = 0;
            end
        end
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
    endtask

    task automatic run_cycle();
        drive();
        @(negedge clk);
        check_and_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit to_alu, input logic [4:0] rd, input logic [XLEN-1:0] d);
        req_t r;
        r.rd = rd;
        r.data = d;
        if (to_alu) aq.push_back(r);
        else        mq.push_back(r);
    endtask

    int ord[4] = '{1, 11, 2, 12};

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_rd = '0;
        rs1_addr = '0;
        rs2_addr = '0;
        model_reset();
        drive();
        repeat (2) run_cycle();
        rst = 1'b0;
        run_cycle();

        // Single write
        push(1, 5'd5, 64'h1234);
        run_cycle();
        check("sw_wen",  wen, 1'b1);
        check("sw_rd",   rd_addr, 5'd5);
        check("sw_data", write_data, 64'h1234);
        run_cycle();
        check("sw_wen_drop", wen, 1'b0);

        // x0 drop from the load side; ptr returns to ALU
        push(0, 5'd0, 64'hFFFF);
        run_cycle();
        check("x0_wen",  wen, 1'b0);
        check("x0_rd",   rd_addr, 5'd5);
        check("x0_data", write_data, 64'h1234);

        // Contention
        for (int i = 0; i < 4; i++) begin
            push(1, 5'(i + 1),  64'(100 + i));
            push(0, 5'(i + 11), 64'(200 + i));
        end
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            check("ct_wen", wen, 1'b1);
            check("ct_order", rd_addr, 5'(ord[i]));
        end
        repeat (5) run_cycle();

        // Scoreboard stall until the write fires
        issue_valid = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;
        run_cycle();
        issue_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sb_stall", stall, 1'b1);
            check("sb_rs2", rs2_busy, 1'b0);
            run_cycle();
        end
        push(1, 5'd7, 64'h77);
        run_cycle();
        check("sb_wen", wen, 1'b1);
        check("sb_stall_drop", stall, 1'b0);

        // Set/clear collision on x9
        issue_valid = 1'b1; issue_rd = 5'd9; rs1_addr = 5'd9;
        run_cycle();
        push(1, 5'd9, 64'h99);
        run_cycle();
        issue_valid = 1'b0;
        check("col_wen", wen, 1'b1);
        check("col_rd", rd_addr, 5'd9);
        check("col_busy", rs1_busy, 1'b1);
        run_cycle();

        // Reset asserted while a write is in the output register
        push(1, 5'd12, 64'hABC);
        push(1, 5'd13, 64'hDEF);
        run_cycle();
        check("pre_rst_wen", wen, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_wen",   wen, 1'b0);
        check("rst_rd",    rd_addr, 5'd0);
        check("rst_data",  write_data, '0);
        check("rst_stall", stall, 1'b0);
        check("rst_ready", alu_ready, 1'b0);
        model_reset();
        repeat (2) run_cycle();
        rst = 1'b0;
        push(1, 5'd3, 64'h33);
        push(0, 5'd4, 64'h44);
        run_cycle();
        check("post_rst_grant", rd_addr, 5'd3);
        repeat (2) run_cycle();

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 2) == 0 && aq.size() < 4)
                push(1, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0 && mq.size() < 4)
                push(0, 5'($urandom_range(0, 31)), {$urandom, $urandom});
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = 5'($urandom_range(0, 31));
            rs1_addr    = 5'($urandom_range(0, 31));
            rs2_addr    = 5'($urandom_range(0, 31));
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the pipeline's 32 x 64-bit register file. Two producers compete for the single register-file write port:
- the ALU write-back path;
- the load (memory) write-back path.

The block grants one of them per cycle with round-robin fairness and drives a registered one-cycle write pulse into the register file's `Wen`/`Rd_addr`/`write_data` inputs. It also tracks destination registers with writes still outstanding and raises a decode-stage stall when a source operand is not yet written.

## Interface

Parameters:
- `XLEN`, 64, data width; matches the register file's data width.
- `NREG`, 32, number of architectural registers. Fixed at 32 because the address width is 5.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — reset, asynchronous and active-high.
- `alu_valid`  in  1  — ALU write-back request.
- `alu_ready`  out  1  — ALU request granted this cycle.
- `alu_rd`  in  5  — ALU destination register.
- `alu_data`  in  XLEN  — ALU result.
- `mem_valid`  in  1  — load write-back request.
- `mem_ready`  out  1  — load request granted this cycle.
- `mem_rd`  in  5  — load destination register.
- `mem_data`  in  XLEN  — load result.
- `issue_valid`  in  1  — an instruction with a destination register is issued.
- `issue_rd`  in  5  — destination register of the issued instruction.
- `rs1_addr`  in  5  — decode-stage source 1 address.
- `rs2_addr`  in  5  — decode-stage source 2 address.
- `rs1_busy`  out  1  — source 1 has an outstanding write.
- `rs2_busy`  out  1  — source 2 has an outstanding write.
- `stall`  out  1  — `rs1_busy | rs2_busy`.
- `wen`  out  1  — register-file write enable; a one-cycle pulse.
- `rd_addr`  out  5  — register-file write address.
- `write_data`  out  XLEN  — register-file write data.

## Operation

**State**
- `ptr` (1 bit): round-robin priority. 0 = ALU favoured, 1 = load favoured.
- `busy[31:0]`: scoreboard vector.
- Output register: `wen`, `rd_addr`, `write_data`.

**Arbitration (combinational)**
- Only ALU valid: `alu_ready=1`.
- Only load valid: `mem_ready=1`.
- Both valid: only the side selected by `ptr` gets ready.
- Neither valid: both readies are 0.
- A transfer fires when `valid & ready`; at most one transfer per cycle.
- Requesters must hold `valid`, `rd` and `data` stable until they fire.

**Priority update**
- On any fire, `ptr` moves to the non-granted side: ALU fire sets `ptr=1`, load fire sets `ptr=0`.
- With no fire, `ptr` holds.

**Output stage**
- On a fire with `rd != 0`: next cycle `wen=1` and `rd_addr`/`write_data` take the granted `rd`/`data`.
- On a fire with `rd == 0`: the transfer is accepted and discarded. `wen=0` and `rd_addr`/`write_data` hold.
- With no fire: `wen=0` and `rd_addr`/`write_data` hold their last values.

**Scoreboard**
- `issue_valid` with `issue_rd != 0` sets `busy[issue_rd]` at the edge.
- A fire with `rd != 0` clears `busy[rd]` at the same edge that raises `wen`.
- Set and clear of the same register in the same cycle: set wins, because the newer producer is outstanding.
- `busy[0]` is constant 0.
- Clearing a bit that is already 0 is legal and has no effect.

**Busy outputs**
- `rsN_busy = busy[rsN_addr]` (combinational from the registered vector).
- An address of 0 always reads not-busy.
- `stall` follows `rs1_busy | rs2_busy` combinationally.

**Reset**
- While `rst` is high: `wen=0`, `rd_addr=0`, `write_data=0`, `ptr=0`, `busy=0`.
- `alu_ready`, `mem_ready`, `stall`, `rsN_busy` are 0 regardless of inputs.
- Reset asserted mid-operation drops any write in the output register immediately; there is no partial `wen` pulse after `rst` rises.
- Requests accepted before reset are lost.

## Timing
- Handshake to register-file write latency: 1 cycle; `wen` is high for exactly one cycle per non-x0 transfer.
- Sustained throughput: 1 write per cycle. Under continuous dual contention, grants alternate ALU, load, ALU, … starting from the current `ptr`.
- Scoreboard set and clear both take effect at the edge. `rsN_busy` reflects them in the cycle after `issue_valid`/fire.
- `busy` clears in the same cycle that `wen` is high. Decode may read the register file in that cycle, because the register file updates combinationally on `wen`.
- No combinational path exists from `alu_valid`/`mem_valid` to `wen`, `rd_addr` or `write_data`.

## Test plan
- **Reset:** assert `rst` mid-stream with `wen=1` → `wen`, `rd_addr`, `write_data`, `busy` and `stall` all read 0 immediately. First request after release with both valid → ALU granted.
- **Single write:** ALU valid, `rd=5`, data `0x1234` at cycle 0 → `alu_ready=1` at cycle 0; at cycle 1 `wen=1`, `rd_addr=5`, `write_data=0x1234`; at cycle 2 `wen=0`.
- **Contention:** both valid for 4 cycles (ALU `rd=1..4`, load `rd=11..14`, each side advancing on its own fire) → grant order ALU(1), load(11), ALU(2), load(12); exactly one ready per cycle; `wen` high for 4 consecutive cycles.
- **x0 drop:** load `rd=0`, data `0xFFFF` → `mem_ready=1`, `wen` stays 0, `rd_addr`/`write_data` unchanged; `ptr` still flips to 0.
- **Scoreboard:** issue `rd=7`, then `rs1_addr=7` → `rs1_busy=1`, `stall=1` until the ALU write of `rd=7` fires; the stall drops in the cycle `wen=1`. `rs2_addr=0` → `rs2_busy=0` throughout.
- **Set/clear collision:** `busy[9]=1`, ALU fires `rd=9` in the same cycle as `issue_valid` with `issue_rd=9` → `wen=1` for `rd=9` next cycle and `busy[9]` remains 1.
